// File: rtl/led_fade_ctrl_pkg.sv
// led_fade_ctrl_pkg: shared defaults and helpers for the LED fade
// controller. Pulls in led_ctrl_defs.vh (widths, FADE_DIV default,
// gamma LUT function led_gamma).
package led_fade_ctrl_pkg;
  `include "led_ctrl_defs.vh"
endpackage

// File: rtl/led_ctrl_defs.vh
// Shared LED controller defaults: brightness/slot widths, fade prescale
// default and the 16-entry perceptual gamma curve. Meant to be included
// inside a package or module body.
`ifndef LED_CTRL_DEFS_VH
`define LED_CTRL_DEFS_VH

localparam int LED_PWM_W_DEF    = 4;
localparam int LED_SLOT_W_DEF   = 4;
localparam int LED_FADE_DIV_DEF = 1024;

// Maps a linear 4-bit level onto a rough perceptual curve.
function automatic logic [3:0] led_gamma(input logic [3:0] v);
  logic [3:0] g;
  case (v)
    4'd0, 4'd1, 4'd2:   g = 4'd0;
    4'd3, 4'd4, 4'd5:   g = 4'd1;
    4'd6, 4'd7:         g = 4'd2;
    4'd8:               g = 4'd3;
    4'd9:               g = 4'd4;
    4'd10:              g = 4'd5;
    4'd11:              g = 4'd6;
    4'd12:              g = 4'd8;
    4'd13:              g = 4'd10;
    4'd14:              g = 4'd12;
    default:            g = 4'd15;
  endcase
  return g;
endfunction

`endif

// File: rtl/led_rr_arb.sv
// led_rr_arb: N-wide round-robin arbiter for a shared resource.
//   clk, rst_n  : clock, synchronous active-low reset
//   valid[N]    : request valids
//   grant[N]    : one-hot grant (combinational); a grant always completes
//                 a transfer since it is only raised on a valid requester
//   grant_idx   : binary index of the granted requester
// The search starts at the pointer and wraps; after a grant the pointer
// moves one past the winner, so a waiting requester is served within N cycles.
module led_rr_arb #(
  parameter int N = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N-1:0]                    valid,
  output logic [N-1:0]                    grant,
  output logic [(N>1?$clog2(N):1)-1:0]    grant_idx
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic          hit;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    hit       = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!hit && valid[(int'(ptr) + k) % N]) begin
        hit       = 1'b1;
        grant_idx = PW'((int'(ptr) + k) % N);
      end
    end
    // nothing is accepted while reset is held
    if (hit && rst_n) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (hit)
      ptr <= (grant_idx == PW'(N-1)) ? '0 : grant_idx + PW'(1);
  end
endmodule

// File: rtl/led_fade_ctrl.sv
// led_fade_ctrl: multi-channel LED fade controller with one shared
// first-order PWM accumulator scanned across NCH outputs.
//   clk, rst_n   : clock, synchronous active-low reset
//   req_valid    : per-requester valid          [NREQ]
//   req_ch       : per-requester channel        [NREQ*CH_W]
//   req_level    : per-requester target level   [NREQ*PWM_W]
//   req_ready    : one-hot accept (combinational)
//   out          : registered LED drives        [NCH]
//   scan_ch      : channel owning the accumulator this slot
//   fade_busy    : some channel has not yet reached its target
// Optional macro LED_GAMMA_EN: PWM level goes through the gamma LUT.
module led_fade_ctrl
  import led_fade_ctrl_pkg::*;
#(
  parameter int NCH      = 8,
  parameter int CH_W     = 3,
  parameter int NREQ     = 2,
  parameter int PWM_W    = LED_PWM_W_DEF,
  parameter int SLOT_W   = LED_SLOT_W_DEF,
  parameter int FADE_DIV = LED_FADE_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CH_W-1:0]  req_ch,
  input  logic [NREQ*PWM_W-1:0] req_level,
  output logic [NREQ-1:0]       req_ready,
  output logic [NCH-1:0]        out,
  output logic [CH_W-1:0]       scan_ch,
  output logic                  fade_busy
);
  localparam int PS_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NCH-1:0][PWM_W-1:0] tgt, cur;
  logic [PS_W-1:0]           presc;
  logic                      tick;
  logic [SLOT_W-1:0]         slot_cnt;
  logic [PWM_W-1:0]          acc;   // residue only; the carry lands in out
  logic [PWM_W:0]            sum;
  logic [PWM_W-1:0]          lvl;
  logic [GW-1:0]             gidx;
  logic [CH_W-1:0]           wr_ch;
  logic [PWM_W-1:0]          wr_lvl;

  led_rr_arb #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .grant     (req_ready),
    .grant_idx (gidx)
  );

  assign wr_ch  = req_ch[int'(gidx)*CH_W +: CH_W];
  assign wr_lvl = req_level[int'(gidx)*PWM_W +: PWM_W];

  assign tick      = (presc == PS_W'(FADE_DIV-1));
  assign fade_busy = (cur != tgt);

`ifdef LED_GAMMA_EN
  assign lvl = PWM_W'(led_gamma(4'(cur[scan_ch])));
`else
  assign lvl = cur[scan_ch];
`endif

  // The residue restarts at zero on each slot so a slot of 2^SLOT_W
  // clocks produces exactly lvl carries.
  assign sum = ((slot_cnt == '0) ? {1'b0, {PWM_W{1'b0}}} : {1'b0, acc})
             + {1'b0, lvl};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt      <= '0;
      cur      <= '0;
      presc    <= '0;
      slot_cnt <= '0;
      scan_ch  <= '0;
      acc      <= '0;
      out      <= '0;
    end else begin
      presc <= tick ? '0 : presc + PS_W'(1);

      // all channels step in parallel against the pre-write targets
      if (tick) begin
        for (int i = 0; i < NCH; i++) begin
          if (cur[i] < tgt[i])      cur[i] <= cur[i] + PWM_W'(1);
          else if (cur[i] > tgt[i]) cur[i] <= cur[i] - PWM_W'(1);
        end
      end

      if (|req_ready) tgt[wr_ch] <= wr_lvl;

      if (slot_cnt == {SLOT_W{1'b1}}) begin
        slot_cnt <= '0;
        scan_ch  <= scan_ch + CH_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end

      acc <= sum[PWM_W-1:0];
      out <= '0;
      if (sum[PWM_W]) out[scan_ch] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_led_fade_ctrl.sv
// Randomized bench for led_fade_ctrl with a lock-step reference model:
// arbitration, fade ramp, scan position derived from elapsed cycles, and
// per-slot PWM pulse counts compared against the channel level.
module tb_led_fade_ctrl;
  localparam int NCH = 8, CH_W = 3, NREQ = 2, PWM_W = 4, SLOT = 16, FD = 4;

  logic                  clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*CH_W-1:0]  req_ch = '0;
  logic [NREQ*PWM_W-1:0] req_level = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NCH-1:0]        out;
  logic [CH_W-1:0]       scan_ch;
  logic                  fade_busy;

  led_fade_ctrl #(.NCH(NCH), .CH_W(CH_W), .NREQ(NREQ), .PWM_W(PWM_W),
                  .SLOT_W(4), .FADE_DIV(FD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ch(req_ch),
    .req_level(req_level), .req_ready(req_ready), .out(out),
    .scan_ch(scan_ch), .fade_busy(fade_busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // reference state
  int tgt_m[NCH], cur_m[NCH];
  int ptr_m = 0, cyc_m = 0;
  int hi_cnt = 0, slot_lvl = 0;
  bit slot_ok = 1'b0;
  logic [NREQ-1:0] last_grant = '0, obs_ready = '0;
  int gtab[16] = '{0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15};

  function automatic int gam(input int v);
`ifdef LED_GAMMA_EN
    return gtab[v];
`else
    return v;
`endif
  endfunction

  function automatic int busy_m();
    for (int i = 0; i < NCH; i++) if (cur_m[i] != tgt_m[i]) return 1;
    return 0;
  endfunction

  // one clock: inputs already applied at the preceding negedge
  task automatic cyc();
    int g, ch, pos, lv;
    logic rs;
    logic [NREQ-1:0] rdy_e;
    g = -1;
    rs = rst_n;
    if (rs)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
    rdy_e = '0;
    if (g >= 0) rdy_e[g] = 1'b1;
    #1;
    obs_ready = req_ready;
    chk("req_ready", int'(req_ready), int'(rdy_e));
    ch  = (cyc_m / SLOT) % NCH;
    pos = cyc_m % SLOT;
    lv  = gam(cur_m[ch]);
    @(posedge clk);
    last_grant = rdy_e;
    if (!rs) begin
      for (int i = 0; i < NCH; i++) begin tgt_m[i] = 0; cur_m[i] = 0; end
      ptr_m = 0; cyc_m = 0; slot_ok = 1'b0;
    end else begin
      if (cyc_m % FD == FD - 1)
        for (int i = 0; i < NCH; i++) begin
          if (cur_m[i] < tgt_m[i]) cur_m[i]++;
          else if (cur_m[i] > tgt_m[i]) cur_m[i]--;
        end
      if (g >= 0) begin
        tgt_m[int'(req_ch[g*CH_W +: CH_W])] = int'(req_level[g*PWM_W +: PWM_W]);
        ptr_m = (g + 1) % NREQ;
      end
      if (pos == 0) begin hi_cnt = 0; slot_lvl = lv; slot_ok = 1'b1; end
      else if (lv != slot_lvl) slot_ok = 1'b0;
      cyc_m++;
    end
    @(negedge clk);
    chk("scan_ch", int'(scan_ch), (cyc_m / SLOT) % NCH);
    chk("fade_busy", int'(fade_busy), busy_m());
    if (!rs) chk("out_in_reset", int'(out), 0);
    else begin
      chk("out_stray", int'(out & ~(NCH'(1) << ch)), 0);
      hi_cnt += int'(out[ch]);
      if (pos == SLOT - 1 && slot_ok) chk("pwm_count", hi_cnt, slot_lvl);
    end
  endtask

  task automatic set_req(input int r, input bit v, input int ch, input int lv);
    req_valid[r] = v;
    req_ch[r*CH_W +: CH_W] = CH_W'(ch);
    req_level[r*PWM_W +: PWM_W] = PWM_W'(lv);
  endtask

  task automatic send(input int r, input int ch, input int lv);
    bit done = 1'b0;
    set_req(r, 1'b1, ch, lv);
    for (int n = 0; n < 8 && !done; n++) begin cyc(); done = last_grant[r]; end
    if (!done) chk("send_timeout", 0, 1);
    set_req(r, 1'b0, 0, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fade_busy && n < 400) begin cyc(); n++; end
    if (n >= 400) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NCH; i++) begin tgt_m[i] = 0; cur_m[i] = 0; end
    // reset
    rst_n = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b1;
    cyc();
    chk("first_out", int'(out), 0);
    repeat (15) cyc();
    chk("scan_after16", int'(scan_ch), 1);

    // fairness: both valid, req0 first then req1
    set_req(0, 1'b1, 1, 5); set_req(1, 1'b1, 3, 9);
    cyc(); chk("fair_first", int'(obs_ready), 1);
    set_req(0, 1'b0, 0, 0);
    cyc(); chk("fair_second", int'(obs_ready), 2);
    // back-to-back: both keep requesting with fresh payloads
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, $urandom_range(0, NCH-1), $urandom_range(0, 15));
      set_req(1, 1'b1, $urandom_range(0, NCH-1), $urandom_range(0, 15));
      cyc(); chk("alternate", int'(obs_ready), 1 << (i % 2));
    end
    set_req(0, 1'b0, 0, 0); set_req(1, 1'b0, 0, 0);
    wait_idle();

    // linear PWM: full scale then mid scale on ch2, others to 0
    for (int c = 0; c < NCH; c++) send(1, c, 0);
    send(0, 2, 15); wait_idle(); repeat (2*NCH*SLOT) cyc();
    send(0, 2, 8);  wait_idle(); repeat (2*NCH*SLOT) cyc();

    // retarget on a tick: 4 -> 5 (old target), then 4, 3, 2
    send(0, 0, 10);
    n = 0;
    while (!(cur_m[0] == 4 && cyc_m % FD == FD - 1) && n < 200) begin cyc(); n++; end
    if (n >= 200) chk("retgt_timeout", 0, 1);
    set_req(0, 1'b1, 0, 2); cyc();
    chk("retgt_accept", int'(obs_ready[0]), 1);
    set_req(0, 1'b0, 0, 0);
    n = 0;
    while (fade_busy && n < 100) begin cyc(); n++; end
    chk("retgt_busy_cycles", n, 3*FD);

    // mid-slot reset on ch5 at level 12
    send(1, 5, 12); wait_idle();
    n = 0;
    while (!(((cyc_m / SLOT) % NCH) == 5 && cyc_m % SLOT == 6) && n < 400) begin cyc(); n++; end
    rst_n = 1'b0; cyc();
    chk("rst_mid_out", int'(out), 0);
    rst_n = 1'b1;
    repeat (2*NCH*SLOT) cyc();

    // random traffic with idle stretches so slots settle
    for (int k = 0; k < 3000; k++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (req_valid[r] && last_grant[r]) set_req(r, 1'b0, 0, 0);
        if (!req_valid[r] && (k % 600) < 200 && $urandom_range(0, 19) == 0)
          set_req(r, 1'b1, $urandom_range(0, NCH-1), $urandom_range(0, 15));
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
